// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP helpers: integer log2 and sign extension
package dsp_pkg;

  localparam int SEXT_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Sign-extends the low w bits of v to SEXT_W bits; callers truncate to their width.
  function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int unsigned w);
    logic signed [SEXT_W-1:0] t;
    t = signed'(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// rtl/sample_delay_line.sv - enable-gated shift register of samples, oldest tap exposed
module sample_delay_line
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_oldest
);

  logic [DATA_WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (i_ce) begin
      taps[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign o_oldest = taps[DEPTH-1];

endmodule

// File: rtl/boxcar_filter.sv
// rtl/boxcar_filter.sv - moving-average filter using a running sum over a sample delay line
module boxcar_filter
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_ce
);

  localparam int LOG2_N    = $clog2(NUM_SAMPLES);
  localparam int ACC_WIDTH = DATA_WIDTH + LOG2_N;

  if (NUM_SAMPLES < 2 || (1 << clog2(NUM_SAMPLES)) != NUM_SAMPLES || DATA_WIDTH < 2) begin : g_bad_params
    $error("boxcar_filter: NUM_SAMPLES must be a power of two >= 2 and DATA_WIDTH >= 2");
  end

  logic        [DATA_WIDTH-1:0] oldest;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  sample_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_SAMPLES)
  ) u_delay (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_data    (i_data),
    .o_oldest  (oldest)
  );

  // The sum of N samples needs LOG2_N extra bits, so this never wraps.
  assign acc_next = acc
                  + ACC_WIDTH'(sext(SEXT_W'(i_data), DATA_WIDTH))
                  - ACC_WIDTH'(sext(SEXT_W'(oldest), DATA_WIDTH));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc    <= '0;
      o_data <= '0;
      o_ce   <= 1'b0;
    end else if (i_ce) begin
      acc    <= acc_next;
      o_data <= DATA_WIDTH'(acc_next >>> LOG2_N);
      o_ce   <= 1'b1;
    end else begin
      o_ce   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boxcar_filter.sv
// tb/tb_boxcar_filter.sv - self-checking bench for boxcar_filter at N=2 and N=4
module tb_boxcar_filter;

  localparam int NOWANT = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce2 = 1'b0, ce4 = 1'b0;
  logic signed [7:0] d2 = '0, d4 = '0;
  logic signed [7:0] out2, out4;
  logic              oce2, oce4;

  int checks = 0;
  int errors = 0;
  int h2[$];
  int h4[$];

  always #5 clk = ~clk;

  boxcar_filter #(.DATA_WIDTH(8), .NUM_SAMPLES(2)) u_n2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce2), .i_data(d2), .o_data(out2), .o_ce(oce2)
  );

  boxcar_filter #(.DATA_WIDTH(8), .NUM_SAMPLES(4)) u_n4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce4), .i_data(d4), .o_data(out4), .o_ce(oce4)
  );

  // Mean of the newest n samples since reset, missing ones counted as zero, floored.
  function automatic int avg(input int h[$], input int n);
    int s, q;
    s = 0;
    for (int i = 0; i < n; i++) if (i < h.size()) s += h[i];
    q = s / n;
    if (s < 0 && q * n != s) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n, input bit ce, input int d, input int want);
    @(negedge clk);
    ce2 = 1'b0;
    ce4 = 1'b0;
    if (n == 2) begin ce2 = ce; d2 = 8'(d); end
    else        begin ce4 = ce; d4 = 8'(d); end
    @(posedge clk);
    #1;
    if (n == 2) begin
      if (ce) h2.push_front(d);
      chk("n2_ce", 32'(oce2), 32'(ce));
      chk("n2_data", 32'(out2), avg(h2, 2));
      if (want != NOWANT) chk("n2_const", 32'(out2), want);
    end else begin
      if (ce) h4.push_front(d);
      chk("n4_ce", 32'(oce4), 32'(ce));
      chk("n4_data", 32'(out4), avg(h4, 4));
      if (want != NOWANT) chk("n4_const", 32'(out4), want);
    end
    if (h2.size() > 8) void'(h2.pop_back());
    if (h4.size() > 8) void'(h4.pop_back());
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ce2 = 1'b0;
    ce4 = 1'b0;
    rst_n = 1'b0;
    #1;
    h2.delete();
    h4.delete();
    chk("rst_async_n2", 32'(out2), 0);
    chk("rst_async_n4", 32'(out4), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with strobes toggling: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ce2 = i[0];
      ce4 = ~i[0];
      d2 = 8'($urandom);
      d4 = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_n2_data", 32'(out2), 0);
      chk("rst_n2_ce", 32'(oce2), 0);
      chk("rst_n4_data", 32'(out4), 0);
      chk("rst_n4_ce", 32'(oce4), 0);
    end
    @(negedge clk);
    ce2 = 1'b0;
    ce4 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(2, 1'b0, 0, 0);

    // Ramp at N=2.
    for (int i = 1; i <= 8; i++) step(2, 1'b1, i, i - 1);
    step(2, 1'b0, 0, 7);

    // Sign crossing at N=2.
    pulse_reset();
    step(2, 1'b1, 12, 6);
    step(2, 1'b1, -1, 5);
    step(2, 1'b1, -2, -2);
    step(2, 1'b1, -3, -3);
    step(2, 1'b1, -4, -4);

    // Gapped ramp at N=2.
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      step(2, 1'b1, i, i - 1);
      for (int g = 0; g < (i % 3); g++) step(2, 1'b0, 99, i - 1);
    end

    // Full scale at N=4.
    pulse_reset();
    for (int i = 1; i <= 4; i++) step(4, 1'b1, -128, -32 * i);
    for (int i = 1; i <= 4; i++) step(4, 1'b1, 127, (i == 4) ? 127 : NOWANT);

    // Mid-stream reset at N=4.
    pulse_reset();
    step(4, 1'b1, 10, 2);
    step(4, 1'b1, 20, 7);
    step(4, 1'b1, 30, 15);
    pulse_reset();
    step(4, 1'b1, 40, 10);

    // Randomized strobes and samples against the reference model.
    for (int i = 0; i < 300; i++) begin
      int d;
      d = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) != 0) ? 127 : -128;
      step((i % 2 == 0) ? 2 : 4, $urandom_range(0, 3) != 0, d, NOWANT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
